gray_step_encoder: RTL and testbench

GRAY_STEP_ENCODER -- requirements
Module: gray_step_encoder

---
 rtl/gray_step_encoder.sv | 103 ++++++++++
 tb/tb_gray_step_encoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/gray_step_encoder.sv
// Prescaled up/down binary counter with a registered Gray-code output and a
// valid/ready handshake: each new code is held until the downstream decoder accepts it.
module gray_step_encoder #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = 27_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             ready,
   output logic [WIDTH-1:0] gray_code,
   output logic [WIDTH-1:0] bin_value,
   output logic             step_valid,
   output logic             wrap
);

   localparam int unsigned     PW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PresLast = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] BinMax  = '1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StHold
   } state_e;

   state_e           state;
   logic [PW-1:0]    presc;
   logic             tick;
   logic [WIDTH-1:0] bin_step;
   logic             step_wrap;

   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   assign tick = enable && (presc == PresLast);

   always_comb begin
      bin_step  = '0;
      step_wrap = 1'b0;
      if (up_down) begin
         bin_step  = bin_value + WIDTH'(1);
         step_wrap = (bin_value == BinMax);
      end else begin
         bin_step  = bin_value - WIDTH'(1);
         step_wrap = (bin_value == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         presc      <= '0;
         bin_value  <= '0;
         gray_code  <= '0;
         step_valid <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         if (load) begin
            presc <= '0;
         end else if (enable) begin
            presc <= (presc == PresLast) ? '0 : presc + PW'(1);
         end

         // A load wins over everything else, including a coincident tick.
         if (load) begin
            bin_value  <= load_value;
            gray_code  <= to_gray(load_value);
            step_valid <= 1'b1;
            wrap       <= 1'b0;
            state      <= StHold;
         end else begin
            unique case (state)
               StIdle, StRun: begin
                  if (tick) begin
                     bin_value  <= bin_step;
                     gray_code  <= to_gray(bin_step);
                     step_valid <= 1'b1;
                     wrap       <= step_wrap;
                     state      <= StHold;
                  end else begin
                     state <= enable ? StRun : StIdle;
                  end
               end
               // Ticks arriving here are dropped so the count never skips a code.
               StHold: begin
                  if (ready) begin
                     step_valid <= 1'b0;
                     wrap       <= 1'b0;
                     state      <= enable ? StRun : StIdle;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gray_step_encoder.sv
// Directed bench for gray_step_encoder with PRESCALE=4, WIDTH=4: a per-cycle vector
// table plus hand-written sequences for the full up count, stalled handshake and pause.
module tb_gray_step_encoder;

   logic       clk = 1'b0;
   logic       rst, enable, up_down, load, ready;
   logic [3:0] load_value;
   logic [3:0] gray_code, bin_value;
   logic       step_valid, wrap;

   int passed = 0;
   int total  = 0;

   gray_step_encoder #(
      .WIDTH   (4),
      .PRESCALE(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .up_down   (up_down),
      .load      (load),
      .load_value(load_value),
      .ready     (ready),
      .gray_code (gray_code),
      .bin_value (bin_value),
      .step_valid(step_valid),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en, ud, ld;
      logic [3:0] lv;
      logic       rdy;
      logic [3:0] g, b;
      logic       v, w;
   } vec_t;

   vec_t       vecs[23];
   logic [3:0] gseq[16];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = 4'h0; ready = 1'b0;
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic wait_valid(output bit found, output int cycles);
      found  = 1'b0;
      cycles = 0;
      for (int i = 1; i <= 12; i++) begin
         if (!found) begin
            next_cycle();
            if (step_valid) begin
               found  = 1'b1;
               cycles = i;
            end
         end
      end
   endtask

   initial begin
      bit found;
      int cycles;
      int unstable;

      // rst en ud ld lv rdy | gray bin valid wrap
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h8, 4'hF, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h8, 4'hF, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h8, 4'hF, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h8, 4'hF, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h9, 4'hE, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h9, 4'hE, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h9, 4'hE, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h9, 4'hE, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 4'hF, 4'hA, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'hF, 4'hA, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 4'h2, 4'h3, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h2, 4'h3, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h2, 4'h3, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h2, 4'h3, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h6, 4'h4, 1'b1, 1'b0};
      vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h6, 4'h4, 1'b1, 1'b0};
      vecs[21] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
      vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};

      gseq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

      rst = 1'b1; enable = 1'b0; up_down = 1'b0; load = 1'b0; load_value = 4'h0; ready = 1'b0;

      // Per-cycle vectors: reset override, down wrap, load over tick, load in hold, reset in hold.
      foreach (vecs[i]) begin
         rst = vecs[i].rst; enable = vecs[i].en; up_down = vecs[i].ud;
         load = vecs[i].ld; load_value = vecs[i].lv; ready = vecs[i].rdy;
         next_cycle();
         check($sformatf("vec%0d_gray", i), gray_code, vecs[i].g);
         check($sformatf("vec%0d_bin", i), bin_value, vecs[i].b);
         check($sformatf("vec%0d_valid", i), step_valid, vecs[i].v);
         check($sformatf("vec%0d_wrap", i), wrap, vecs[i].w);
      end

      // Full up count with the first code stalled for 20 cycles.
      do_reset();
      enable = 1'b1; up_down = 1'b1; ready = 1'b0;
      for (int k = 0; k < 16; k++) begin
         wait_valid(found, cycles);
         check($sformatf("up_found[%0d]", k), found, 1);
         if (k != 1) check($sformatf("up_spacing[%0d]", k), cycles, 4);
         check($sformatf("up_gray[%0d]", k), gray_code, gseq[k]);
         check($sformatf("up_bin[%0d]", k), bin_value, (k + 1) % 16);
         check($sformatf("up_wrap[%0d]", k), wrap, (k == 15) ? 1 : 0);
         if (k == 0) begin
            unstable = 0;
            for (int c = 0; c < 20; c++) begin
               next_cycle();
               if (!step_valid || gray_code != 4'h1 || bin_value != 4'h1) unstable++;
            end
            check("stall_stable", unstable, 0);
            ready = 1'b1;
            next_cycle();
            check("stall_release_valid", step_valid, 0);
            check("stall_release_gray", gray_code, 4'h1);
         end
      end
      next_cycle();
      check("wrap_clears", wrap, 0);

      // Pause at prescale count 2: exactly one further enabled cycle before the tick.
      do_reset();
      enable = 1'b1; up_down = 1'b1; ready = 1'b1;
      next_cycle();
      next_cycle();
      enable = 1'b0;
      for (int c = 0; c < 3; c++) next_cycle();
      check("pause_bin", bin_value, 0);
      enable = 1'b1;
      next_cycle();
      check("resume_bin_early", bin_value, 0);
      check("resume_valid_early", step_valid, 0);
      next_cycle();
      check("resume_bin", bin_value, 1);
      check("resume_valid", step_valid, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
